// File: rtl/regdbg_pkg.sv
// -----------------------------------------------------------------------------
// regdbg_pkg
// Shared constants and types for the register-file debug port: register
// geometry, FSM state encoding, host command opcodes and word-shifter modes.
// -----------------------------------------------------------------------------
package regdbg_pkg;

    localparam int XLEN  = 32;                 // register width, multiple of 8
    localparam int NREGS = 32;                 // register count
    localparam int BYTES = XLEN / 8;           // bytes per register word
    localparam int AW    = $clog2(NREGS);      // register index width
    localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [AW-1:0]  LAST_IDX  = AW'(NREGS - 1);
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_COLLECT,
        S_LD_WRITE,
        S_DP_READ,
        S_DP_SEND,
        S_FINISH
    } state_e;

    typedef enum logic {
        OP_DUMP = 1'b0,
        OP_LOAD = 1'b1
    } op_e;

    typedef enum logic [2:0] {
        SH_HOLD,       // keep word and byte count
        SH_CLEAR,      // restart byte count, keep word
        SH_LOAD,       // parallel load of a whole word, restart byte count
        SH_SHIFT_IN,   // new byte enters at the top (little-endian assembly)
        SH_SHIFT_OUT   // low byte leaves at the bottom (little-endian streaming)
    } sh_mode_e;

endpackage

// File: rtl/regdbg_word_shifter.sv
// -----------------------------------------------------------------------------
// regdbg_word_shifter
// XLEN-wide shift register with a byte counter, shared by the LOAD path
// (bytes shifted in at the top) and the DUMP path (word loaded in parallel,
// bytes shifted out at the bottom).
//
// Ports
//   clk          in   clock
//   rst          in   asynchronous active-high reset
//   mode_i       in   operation for this cycle (sh_mode_e)
//   par_i        in   parallel word for SH_LOAD
//   byte_i       in   byte for SH_SHIFT_IN
//   word_o       out  current shift-register contents
//   last_byte_o  out  byte counter points at the final byte of the word
// -----------------------------------------------------------------------------
module regdbg_word_shifter
    import regdbg_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  sh_mode_e        mode_i,
    input  logic [XLEN-1:0] par_i,
    input  logic [7:0]      byte_i,
    output logic [XLEN-1:0] word_o,
    output logic            last_byte_o
);

    logic [XLEN-1:0] shreg_q, shreg_d;
    logic [BCW-1:0]  bcnt_q,  bcnt_d;
    logic [BCW-1:0]  bcnt_inc;

    assign last_byte_o = (bcnt_q == LAST_BYTE);
    // Explicit wrap so a non-power-of-two BYTES still counts modulo BYTES.
    assign bcnt_inc    = last_byte_o ? '0 : bcnt_q + BCW'(1);
    assign word_o      = shreg_q;

    always_comb begin
        shreg_d = shreg_q;
        bcnt_d  = bcnt_q;
        case (mode_i)
            SH_CLEAR: begin
                bcnt_d = '0;
            end
            SH_LOAD: begin
                shreg_d = par_i;
                bcnt_d  = '0;
            end
            SH_SHIFT_IN: begin
                shreg_d = {byte_i, shreg_q[XLEN-1:8]};
                bcnt_d  = bcnt_inc;
            end
            SH_SHIFT_OUT: begin
                shreg_d = shreg_q >> 8;
                bcnt_d  = bcnt_inc;
            end
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
            bcnt_q  <= '0;
        end else begin
            shreg_q <= shreg_d;
            bcnt_q  <= bcnt_d;
        end
    end

endmodule

// File: rtl/regfile_debug_port.sv
// -----------------------------------------------------------------------------
// regfile_debug_port
// Debug initiator for the CPU register file. LOAD fills x1..x(NREGS-1) from a
// little-endian byte stream; DUMP streams x0..x(NREGS-1) out as bytes. The
// register-file port is owned only while busy=1, with the core held by
// cpu_halt for that window.
//
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   cmd_valid/ready/op     host command handshake (op: 0=DUMP, 1=LOAD)
//   in_valid/ready/data    LOAD byte stream
//   out_valid/ready/data   DUMP byte stream
//   rf_rs1, rf_rdata       register-file read address (registered) / data
//   rf_rd, rf_wdata, rf_we register-file write port
//   busy, cpu_halt         not idle; core stall request
//   done                   one-cycle completion pulse
// -----------------------------------------------------------------------------
module regfile_debug_port
    import regdbg_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_op,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [7:0]      in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [7:0]      out_data,
    output logic [AW-1:0]   rf_rs1,
    input  logic [XLEN-1:0] rf_rdata,
    output logic [AW-1:0]   rf_rd,
    output logic [XLEN-1:0] rf_wdata,
    output logic            rf_we,
    output logic            busy,
    output logic            cpu_halt,
    output logic            done
);

    state_e          state_q, state_d;
    logic [AW-1:0]   idx_q,   idx_d;
    logic [AW-1:0]   rs1_q,   rs1_d;
    logic [AW-1:0]   rd_q,    rd_d;
    logic [AW-1:0]   start_idx;
    sh_mode_e        sh_mode;
    logic [XLEN-1:0] word;
    logic            last_byte;

    regdbg_word_shifter u_shifter (
        .clk         (clk),
        .rst         (rst),
        .mode_i      (sh_mode),
        .par_i       (rf_rdata),
        .byte_i      (in_data),
        .word_o      (word),
        .last_byte_o (last_byte)
    );

    // NOTE: every signal written below gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        rs1_d     = rs1_q;
        rd_d      = rd_q;
        sh_mode   = SH_HOLD;
        cmd_ready = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        rf_we     = 1'b0;
        done      = 1'b0;
        // x0 is never loaded, so LOAD starts at index 1 and DUMP at 0.
        start_idx = (op_e'(cmd_op) == OP_LOAD) ? AW'(1) : '0;

        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    sh_mode = SH_CLEAR;
                    idx_d   = start_idx;
                    rs1_d   = start_idx;
                    rd_d    = start_idx;
                    state_d = (op_e'(cmd_op) == OP_LOAD) ? S_LD_COLLECT : S_DP_READ;
                end
            end
            S_LD_COLLECT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    sh_mode = SH_SHIFT_IN;
                    if (last_byte) state_d = S_LD_WRITE;
                end
            end
            S_LD_WRITE: begin
                rf_we   = 1'b1;
                sh_mode = SH_CLEAR;
                if (idx_q == LAST_IDX) begin
                    state_d = S_FINISH;
                end else begin
                    idx_d   = idx_q + AW'(1);
                    rd_d    = idx_q + AW'(1);
                    state_d = S_LD_COLLECT;
                end
            end
            S_DP_READ: begin
                // rf_rs1 was registered on the previous edge, so rf_rdata is settled.
                sh_mode = SH_LOAD;
                state_d = S_DP_SEND;
            end
            S_DP_SEND: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    sh_mode = SH_SHIFT_OUT;
                    if (last_byte) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = S_FINISH;
                        end else begin
                            idx_d   = idx_q + AW'(1);
                            rs1_d   = idx_q + AW'(1);
                            state_d = S_DP_READ;
                        end
                    end
                end
            end
            S_FINISH: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            rs1_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rs1_q   <= rs1_d;
            rd_q    <= rd_d;
        end
    end

    assign rf_rs1   = rs1_q;
    assign rf_rd    = rd_q;
    assign rf_wdata = word;
    assign out_data = word[7:0];
    assign busy     = (state_q != S_IDLE);
    assign cpu_halt = busy;

endmodule
